op_data_ctrl: RTL and testbench
===============================

Name: op_data_ctrl

Overview:
- Sequencer for the BXU data-cell datapath unit.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and decodes the opcode.
- Fetches the current cell from data memory when needed, waits for input-stream bytes on GET, then drives the datapath's operation flag and write-back flag with correct timing.
- Sits between the instruction dispatcher and the data datapath; also services PUT (cell to output stream).

Parameters:
- DATA_BITWIDTH, 8, cell/stream byte width
- CODE_BITWIDTH, 16, instruction width
- TIMEOUT_CYCLES, 1024, GET input wait limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  instruction offered
- inst_ready  out  1  controller idle, can accept
- inst_code  in  16  instruction word
- mem_rd_en  out  1  one-cycle cell read request
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  8  current cell value
- in_valid  in  1  input-stream byte available
- in_ready  out  1  input byte consumed this cycle
- in_data  in  8  input-stream byte
- out_valid  out  1  PUT byte offered
- out_ready  in  1  output sink accepts
- out_data  out  8  PUT byte
- flag_op_data  out  2  datapath op: NOP=0, MOD=1, SET=2, GET=3
- flag_op_data_wr  out  1  datapath write-back strobe
- op_code  out  16  latched instruction to datapath
- op_data  out  8  latched cell value to datapath
- op_in  out  8  latched input byte to datapath
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag

Behaviour:
- Opcode is inst_code[3:0]: 1=MOD, 2=SET, 3=GET, 4=PUT; every other value is NOP.
- Flag bits: code[13] selects SET-from-memory; code[11:4] is imm8.
- Reset values: state IDLE; op_code, op_data, op_in, out_data = 0; flag_op_data = NOP; flag_op_data_wr, mem_rd_en, in_ready, out_valid, done, busy, err = 0. inst_ready = 1 once rst_n deasserts.
- States: IDLE, RD, RDW, WAIT_IN, EXEC, WB, WR, OUT, DONE.
- IDLE:
  - inst_ready=1.
  - On inst_valid: latch inst_code into op_code, then:
    - MOD, SET with code[13]=1, PUT -> RD.
    - SET with code[13]=0 -> EXEC.
    - GET -> WAIT_IN.
    - NOP -> DONE.
- RD: mem_rd_en=1 for exactly one cycle -> RDW.
- RDW:
  - On mem_rd_valid: latch mem_rd_data into op_data.
  - Next state is OUT for PUT, otherwise EXEC.
  - Waits indefinitely without the optional feature.
  - mem_rd_valid arriving in the RD cycle itself is accepted identically.
- WAIT_IN:
  - in_ready = in_valid (combinational).
  - On in_valid: latch in_data into op_in -> EXEC.
- EXEC: flag_op_data = decoded op for exactly one cycle. The datapath registers its result at the end of this cycle.
- WB: flag_op_data_wr=1 for exactly one cycle. flag_op_data=NOP.
- WR: one idle cycle so the datapath's half-cycle-delayed write strobe completes -> DONE.
- OUT:
  - out_valid=1, out_data=op_data, held stable until out_ready.
  - On out_ready -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- flag_op_data is NOP in every state except EXEC; at most one EXEC per instruction.
- Latency, handshake edge to done: SET-imm 4 cycles, NOP 1 cycle. MOD and SET-mem take 4 cycles plus RD/RDW time; GET takes 4 cycles plus input wait.
- A new instruction is never accepted while busy; inst_valid held during busy is ignored until IDLE.
- Reset asserted mid-instruction: immediate return to IDLE with the reset values above. No partial write strobe survives.

Optional Feature:
- Macro: OP_DATA_CTRL_TIMEOUT_EN.
- With it:
  - A counter runs in WAIT_IN and RDW; it clears on entering either state.
  - When the counter reaches TIMEOUT_CYCLES-1 without a handshake: set err (sticky until reset) and jump to DONE. No EXEC and no write-back are issued.
- Without it: no counter exists, those states wait forever, and err is tied to 0.

Decomposition:
- Shared package bxu_pkg holds:
  - DATA_NOP/MOD/SET/GET 2-bit constants.
  - Opcode constants OPC_MOD/SET/GET/PUT.
  - Field positions: F_PN=15, F_MEM=13, F_LH=12, IMM hi/lo = 11/4.
  - State enum typedef.
- Single FSM module; no sub-module warranted (the timeout counter stays inline).

Test Plan:
- SET-imm code=16'h0422 handshake at cycle 0 -> flag_op_data=2 in cycle 1, flag_op_data_wr in cycle 2, done in cycle 4, no mem_rd_en.
- MOD code=16'h8051, mem_rd_data=8'h10 returned one cycle after mem_rd_en -> op_data=8'h10, exactly one EXEC with flag=1, one wr strobe, done.
- GET code=16'h0003, in_valid held low 5 cycles then 8'hA5 -> in_ready pulses once, op_in=8'hA5, EXEC flag=3 follows next cycle.
- PUT code=16'h0004, cell 8'h3C, out_ready low 3 cycles -> out_valid and out_data=8'h3C stable until accept, flag_op_data stays NOP, no wr strobe.
- Reset pulsed during WB -> next cycle all outputs at reset values, inst_ready=1, the following instruction runs normally.
- With OP_DATA_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: GET with no input -> err=1 and done after 16 WAIT_IN cycles, no EXEC.

Source files
------------

// File: rtl/bxu_pkg.sv
// Shared BXU definitions: datapath op codes, opcodes,
// instruction field positions and sequencer state encoding.
package bxu_pkg;

  localparam logic [1:0] DATA_NOP = 2'd0;
  localparam logic [1:0] DATA_MOD = 2'd1;
  localparam logic [1:0] DATA_SET = 2'd2;
  localparam logic [1:0] DATA_GET = 2'd3;

  localparam logic [3:0] OPC_MOD = 4'd1;
  localparam logic [3:0] OPC_SET = 4'd2;
  localparam logic [3:0] OPC_GET = 4'd3;
  localparam logic [3:0] OPC_PUT = 4'd4;

  localparam int F_PN     = 15;
  localparam int F_MEM    = 13;
  localparam int F_LH     = 12;
  localparam int F_IMM_HI = 11;
  localparam int F_IMM_LO = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_WAIT_IN,
    S_EXEC,
    S_WB,
    S_WR,
    S_OUT,
    S_DONE
  } state_t;

  function automatic logic [1:0] data_op(
    input logic [3:0] opc
  );
    logic [1:0] r;
    r = DATA_NOP;
    case (opc)
      OPC_MOD: r = DATA_MOD;
      OPC_SET: r = DATA_SET;
      OPC_GET: r = DATA_GET;
      default: r = DATA_NOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/op_data_ctrl.sv
// BXU data-cell sequencer: decode, cell fetch, input wait, exec/write-back.
// OP_DATA_CTRL_TIMEOUT_EN adds a wait timeout with a sticky err flag.
module op_data_ctrl
  import bxu_pkg::*;
#(
  parameter int DATA_BITWIDTH  = 8,
  parameter int CODE_BITWIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic [CODE_BITWIDTH-1:0] inst_code,
  output logic                     mem_rd_en,
  input  logic                     mem_rd_valid,
  input  logic [DATA_BITWIDTH-1:0] mem_rd_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic [1:0]               flag_op_data,
  output logic                     flag_op_data_wr,
  output logic [CODE_BITWIDTH-1:0] op_code,
  output logic [DATA_BITWIDTH-1:0] op_data,
  output logic [DATA_BITWIDTH-1:0] op_in,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  state_t     state;
  logic [3:0] opc;
  logic [3:0] new_opc;
  logic       is_put;
  logic       tmo;

  assign opc        = op_code[3:0];
  assign new_opc    = inst_code[3:0];
  assign is_put     = (opc == OPC_PUT);
  assign inst_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign in_ready   = (state == S_WAIT_IN) && in_valid;

`ifdef OP_DATA_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] to_cnt;
  logic          in_wait;

  assign in_wait = (state == S_WAIT_IN) || (state == S_RDW);
  assign tmo = (to_cnt == TW'(TIMEOUT_CYCLES - 1))
    && (((state == S_WAIT_IN) && !in_valid)
    || ((state == S_RDW) && !mem_rd_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      to_cnt <= in_wait ? to_cnt + 1'b1 : '0;
      if (tmo) err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      op_code         <= '0;
      op_data         <= '0;
      op_in           <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      mem_rd_en       <= 1'b0;
      flag_op_data    <= DATA_NOP;
      flag_op_data_wr <= 1'b0;
      done            <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (inst_valid) begin
            op_code <= inst_code;
            unique case (1'b1)
              (new_opc == OPC_MOD),
              (new_opc == OPC_PUT),
              (new_opc == OPC_SET && inst_code[F_MEM]): begin
                state     <= S_RD;
                mem_rd_en <= 1'b1;
              end
              (new_opc == OPC_SET && !inst_code[F_MEM]): begin
                state        <= S_EXEC;
                flag_op_data <= DATA_SET;
              end
              (new_opc == OPC_GET): state <= S_WAIT_IN;
              default: begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        S_RD: begin
          mem_rd_en <= 1'b0;
          if (mem_rd_valid) begin
            op_data <= mem_rd_data;
            if (is_put) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_data  <= mem_rd_data;
            end else begin
              state        <= S_EXEC;
              flag_op_data <= data_op(opc);
            end
          end else begin
            state <= S_RDW;
          end
        end
        S_RDW: begin
          if (mem_rd_valid) begin
            op_data <= mem_rd_data;
            if (is_put) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_data  <= mem_rd_data;
            end else begin
              state        <= S_EXEC;
              flag_op_data <= data_op(opc);
            end
          end else if (tmo) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            op_in        <= in_data;
            state        <= S_EXEC;
            flag_op_data <= DATA_GET;
          end else if (tmo) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_EXEC: begin
          state           <= S_WB;
          flag_op_data    <= DATA_NOP;
          flag_op_data_wr <= 1'b1;
        end
        S_WB: begin
          state           <= S_WR;
          flag_op_data_wr <= 1'b0;
        end
        S_WR: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_DONE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op_data_ctrl.sv
// Directed bench for op_data_ctrl.
// Define OP_DATA_CTRL_TIMEOUT_EN to also exercise the GET timeout.
module tb_op_data_ctrl;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_code;
  logic        mem_rd_en;
  logic        mem_rd_valid;
  logic [7:0]  mem_rd_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  flag_op_data;
  logic        flag_op_data_wr;
  logic [15:0] op_code;
  logic [7:0]  op_data;
  logic [7:0]  op_in;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int errors;
  int n_rd, n_exec, n_wr, n_inr;
  int b_rd, b_exec, b_wr, b_inr;

  op_data_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_code       (inst_code),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .flag_op_data    (flag_op_data),
    .flag_op_data_wr (flag_op_data_wr),
    .op_code         (op_code),
    .op_data         (op_data),
    .op_in           (op_in),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_rd = 0; n_exec = 0; n_wr = 0; n_inr = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) n_rd++;
      if (flag_op_data != 2'd0) n_exec++;
      if (flag_op_data_wr) n_wr++;
      if (in_ready) n_inr++;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_rd = n_rd; b_exec = n_exec; b_wr = n_wr; b_inr = n_inr;
  endtask

  task automatic issue(input logic [15:0] code);
    inst_code  = code;
    inst_valid = 1'b1;
    chk("inst_ready_idle", inst_ready, 1);
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k;
    k = 0;
    while (done !== 1'b1 && k < lim) begin
      tick();
      k++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    inst_valid   = 1'b0;
    inst_code    = '0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("rst_inst_ready", inst_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_flag", flag_op_data, 0);
    chk("rst_wr", flag_op_data_wr, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_op_code", op_code, 0);
    chk("rst_out_data", out_data, 0);

    // SET-imm with inst_valid held and code changed while busy
    snap();
    inst_code  = 16'h0422;
    inst_valid = 1'b1;
    tick();
    inst_code = 16'h0001;
    chk("seti_c1_flag", flag_op_data, 2);
    chk("seti_c1_ready", inst_ready, 0);
    chk("seti_op_code", op_code, 16'h0422);
    tick();
    chk("seti_c2_wr", flag_op_data_wr, 1);
    chk("seti_c2_flag", flag_op_data, 0);
    tick();
    chk("seti_c3_wr", flag_op_data_wr, 0);
    chk("seti_c3_done", done, 0);
    chk("seti_op_code_hold", op_code, 16'h0422);
    inst_valid = 1'b0;
    tick();
    chk("seti_c4_done", done, 1);
    tick();
    chk("seti_idle_done", done, 0);
    chk("seti_idle_ready", inst_ready, 1);
    chk("seti_no_rd", n_rd - b_rd, 0);
    chk("seti_one_exec", n_exec - b_exec, 1);

    // NOP: done one cycle after handshake
    snap();
    issue(16'h000F);
    chk("nop_done", done, 1);
    tick();
    chk("nop_exec", n_exec - b_exec, 0);
    chk("nop_wr", n_wr - b_wr, 0);

    // Modify op with data one cycle after mem_rd_en
    snap();
    issue(16'h8051);
    chk("mod_rd_en", mem_rd_en, 1);
    tick();
    chk("mod_rd_en_off", mem_rd_en, 0);
    mem_rd_valid = 1'b1;
    mem_rd_data  = 8'h10;
    tick();
    mem_rd_valid = 1'b0;
    mem_rd_data  = 8'hEE;
    chk("mod_flag", flag_op_data, 1);
    chk("mod_op_data", op_data, 8'h10);
    wait_done("mod_done", 10);
    tick();
    chk("mod_rd_cnt", n_rd - b_rd, 1);
    chk("mod_exec_cnt", n_exec - b_exec, 1);
    chk("mod_wr_cnt", n_wr - b_wr, 1);

    // SET-mem with read data in the RD cycle itself
    snap();
    mem_rd_valid = 1'b1;
    mem_rd_data  = 8'h77;
    issue(16'h2012);
    chk("setm_rd_en", mem_rd_en, 1);
    tick();
    mem_rd_valid = 1'b0;
    chk("setm_flag", flag_op_data, 2);
    chk("setm_op_data", op_data, 8'h77);
    wait_done("setm_done", 10);
    tick();
    chk("setm_exec_cnt", n_exec - b_exec, 1);
    chk("setm_wr_cnt", n_wr - b_wr, 1);

    // GET: input held off for 5 cycles
    snap();
    issue(16'h0003);
    for (int i = 0; i < 5; i++) begin
      chk("get_wait_inr", in_ready, 0);
      chk("get_wait_busy", busy, 1);
      tick();
    end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    chk("get_inr", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("get_flag", flag_op_data, 3);
    chk("get_op_in", op_in, 8'hA5);
    chk("get_inr_off", in_ready, 0);
    wait_done("get_done", 10);
    tick();
    chk("get_inr_cnt", n_inr - b_inr, 1);
    chk("get_exec_cnt", n_exec - b_exec, 1);
    chk("get_no_rd", n_rd - b_rd, 0);

    // PUT: sink stalls 3 cycles
    snap();
    issue(16'h0004);
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_data  = 8'h3C;
    tick();
    mem_rd_valid = 1'b0;
    mem_rd_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk("put_valid", out_valid, 1);
      chk("put_data", out_data, 8'h3C);
      chk("put_done_low", done, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("put_done", done, 1);
    chk("put_valid_off", out_valid, 0);
    tick();
    chk("put_exec_cnt", n_exec - b_exec, 0);
    chk("put_wr_cnt", n_wr - b_wr, 0);
    chk("put_rd_cnt", n_rd - b_rd, 1);

    // Reset asserted during WB
    issue(16'h0422);
    tick();
    chk("rstwb_wr", flag_op_data_wr, 1);
    rst_n = 1'b0;
    #1;
    chk("rstwb_wr_clr", flag_op_data_wr, 0);
    chk("rstwb_busy", busy, 0);
    chk("rstwb_op_code", op_code, 0);
    chk("rstwb_flag", flag_op_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rstwb_ready", inst_ready, 1);
    chk("rstwb_done", done, 0);
    snap();
    issue(16'h0A12);
    chk("rerun_flag", flag_op_data, 2);
    chk("rerun_op_code", op_code, 16'h0A12);
    tick();
    chk("rerun_wr", flag_op_data_wr, 1);
    tick();
    tick();
    chk("rerun_done", done, 1);
    tick();
    chk("rerun_wr_cnt", n_wr - b_wr, 1);

`ifdef OP_DATA_CTRL_TIMEOUT_EN
    // GET with no input times out after 16 wait cycles
    snap();
    issue(16'h0003);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_not_yet", done, 0);
    chk("tmo_busy", busy, 1);
    chk("tmo_err_low", err, 0);
    tick();
    chk("tmo_done", done, 1);
    chk("tmo_err", err, 1);
    tick();
    chk("tmo_err_sticky", err, 1);
    chk("tmo_exec_cnt", n_exec - b_exec, 0);
    chk("tmo_wr_cnt", n_wr - b_wr, 0);
`else
    chk("err_tied", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
